// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cpu_pkg                                                |
// | Description : Shared fetch constants, exception codes, queue entry.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR            = 32'h00000013;
    localparam logic [3:0]  EXC_INSTR_MISALIGNED = 4'd0;
    localparam logic [3:0]  EXC_INSTR_ACCESS     = 4'd1;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        exc_en;
        logic [3:0]  exc_code;
        logic [63:0] exc_val;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fetch_fifo                                             |
// | Description : DEPTH-entry circular queue of fetch entries with flush.|
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           push,
    input  fetch_entry_t                   push_data,
    input  logic                           pop,
    output fetch_entry_t                   head,
    output logic                           empty,
    output logic                           full,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int c_cw = $clog2(DEPTH + 1);
    localparam int c_pw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t       r_mem [DEPTH];
    logic [c_pw-1:0]    r_wr_ptr;
    logic [c_pw-1:0]    r_rd_ptr;
    logic [c_cw-1:0]    r_count;
    logic               w_push;
    logic               w_pop;

    function automatic logic [c_pw-1:0] ptr_inc(input logic [c_pw-1:0] p);
        return (p == c_pw'(DEPTH - 1)) ? '0 : p + c_pw'(1);
    endfunction

    assign w_pop  = pop && (r_count != '0);
    assign w_push = push && (!full || w_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cw'(1);
                2'b01:   r_count <= r_count - c_cw'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign empty = (r_count == '0);
    assign full  = (r_count == c_cw'(DEPTH));
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/ifetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ifetch_ctrl                                            |
// | Description : Fetch PC sequencing, fault screening, redirect flush.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ifetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          MEM_WORDS = 2048,
    parameter int          DEPTH     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_en,
    input  logic [63:0] redirect_pc,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [63:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_exc_en,
    output logic [3:0]  if_exc_code,
    output logic [63:0] if_exc_val
);

    localparam int          c_cw        = $clog2(DEPTH + 1);
    localparam logic [0:0]  c_st_run    = 1'b0;
    localparam logic [0:0]  c_st_fault  = 1'b1;
    localparam logic [61:0] c_mem_words = 62'(MEM_WORDS);
    localparam logic [c_cw:0] c_depth   = (c_cw + 1)'(DEPTH);

    logic [0:0]      r_state;
    logic [0:0]      w_state_next;
    logic [63:0]     r_pc;
    logic            r_inf_valid;
    logic            r_inf_fault;
    logic [3:0]      r_inf_code;
    logic [63:0]     r_inf_pc;

    logic            w_pop;
    logic            w_push;
    logic            w_issue;
    logic            w_misaligned;
    logic            w_oob;
    logic            w_fault;
    logic [c_cw:0]   w_used;
    logic [c_cw-1:0] w_count;
    logic            w_empty;
    logic            w_full;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_entry;

    assign w_misaligned = (r_pc[1:0] != 2'b00);
    assign w_oob        = (r_pc[63:2] >= c_mem_words);
    assign w_fault      = w_misaligned || w_oob;
    assign w_pop        = if_valid && if_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_run;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (redirect_en) begin
            w_state_next = c_st_run;
        end else if (w_issue && w_fault) begin
            w_state_next = c_st_fault;
        end
    end

    // Credit counts queued plus in-flight entries, freeing the slot a pop releases this cycle
    always_comb begin
        w_used   = {1'b0, w_count} + {{c_cw{1'b0}}, r_inf_valid} - {{c_cw{1'b0}}, w_pop};
        w_issue  = !rst && (r_state == c_st_run) && !redirect_en && (w_used < c_depth);
        mem_req  = 1'b0;
        mem_addr = 64'd0;
        if (w_issue && !w_fault) begin
            mem_req  = 1'b1;
            mem_addr = r_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_inf_valid <= 1'b0;
            r_inf_fault <= 1'b0;
            r_inf_code  <= 4'd0;
            r_inf_pc    <= 64'd0;
        end else if (redirect_en) begin
            r_pc        <= redirect_pc;
            r_inf_valid <= 1'b0;
            r_inf_fault <= 1'b0;
            r_inf_code  <= 4'd0;
        end else begin
            r_inf_valid <= w_issue;
            r_inf_fault <= w_fault;
            r_inf_code  <= w_misaligned ? EXC_INSTR_MISALIGNED : EXC_INSTR_ACCESS;
            r_inf_pc    <= r_pc;
            if (w_issue && !w_fault) begin
                r_pc <= r_pc + 64'd4;
            end
        end
    end

    // Fault slots never touched memory, so their payload is synthesised here
    always_comb begin
        w_push_entry.pc       = r_inf_pc;
        w_push_entry.instr    = r_inf_fault ? NOP_INSTR : mem_rdata;
        w_push_entry.exc_en   = r_inf_fault;
        w_push_entry.exc_code = r_inf_fault ? r_inf_code : 4'd0;
        w_push_entry.exc_val  = r_inf_fault ? r_inf_pc : 64'd0;
    end

    assign w_push = r_inf_valid && !redirect_en && (!w_full || w_pop);

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_en),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .head      (w_head),
        .empty     (w_empty),
        .full      (w_full),
        .count     (w_count)
    );

    assign if_valid = !w_empty;

    always_comb begin
        if_pc       = 64'd0;
        if_instr    = NOP_INSTR;
        if_exc_en   = 1'b0;
        if_exc_code = 4'd0;
        if_exc_val  = 64'd0;
        if (if_valid) begin
            if_pc       = w_head.pc;
            if_instr    = w_head.instr;
            if_exc_en   = w_head.exc_en;
            if_exc_code = w_head.exc_code;
            if_exc_val  = w_head.exc_val;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_ifetch_ctrl                                         |
// | Description : Self-checking bench for ifetch_ctrl with ref model.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_ifetch_ctrl;
    import cpu_pkg::*;

    localparam int c_words = 2048;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_en = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic [31:0] mem_rdata = 32'd0;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        if_exc_en;
    logic [3:0]  if_exc_code;
    logic [63:0] if_exc_val;

    always #5 clk = ~clk;

    ifetch_ctrl #(
        .RESET_PC  (64'h0),
        .MEM_WORDS (c_words),
        .DEPTH     (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
        .if_exc_en   (if_exc_en),
        .if_exc_code (if_exc_code),
        .if_exc_val  (if_exc_val)
    );

    // imem: word i holds i; unrequested cycles return a poison pattern
    logic [31:0] imem [c_words];
    initial for (int i = 0; i < c_words; i++) imem[i] = 32'(i);
    always @(posedge clk) mem_rdata <= mem_req ? imem[mem_addr[12:2]] : 32'hDEAD_BEEF;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what decode should see, and what fetch should be pending
    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        exc;
        logic [3:0]  code;
        logic [63:0] val;
    } ent_t;

    ent_t        m_q[$];
    ent_t        m_pend[$];
    logic [63:0] m_pc = 64'd0;
    bit          m_fault = 1'b0;
    bit          m_live = 1'b0;

    function automatic bit m_faulty(input logic [63:0] pc);
        return (pc % 64'd4 != 64'd0) || ((pc >> 2) >= 64'(c_words));
    endfunction

    function automatic ent_t make_entry(input logic [63:0] pc);
        ent_t e;
        if (pc % 64'd4 != 64'd0)            e = '{pc, 32'h13, 1'b1, 4'd0, pc};
        else if ((pc >> 2) >= 64'(c_words)) e = '{pc, 32'h13, 1'b1, 4'd1, pc};
        else                                e = '{pc, imem[pc[12:2]], 1'b0, 4'd0, 64'd0};
        return e;
    endfunction

    function automatic bit m_pop();
        return (m_q.size() > 0) && if_ready;
    endfunction

    function automatic bit m_issue();
        int occ = m_q.size() + m_pend.size() - (m_pop() ? 1 : 0);
        return !rst && !m_fault && !redirect_en && (occ < 2);
    endfunction

    always @(posedge clk) begin : model_update
        bit p;
        bit iss;
        if (rst) begin
            m_q.delete();
            m_pend.delete();
            m_pc    = 64'd0;
            m_fault = 1'b0;
            m_live  = 1'b1;
        end else if (redirect_en) begin
            m_q.delete();
            m_pend.delete();
            m_pc    = redirect_pc;
            m_fault = 1'b0;
        end else begin
            p   = m_pop();
            iss = m_issue();
            if (p) void'(m_q.pop_front());
            if (m_pend.size() > 0) m_q.push_back(m_pend.pop_front());
            if (iss) begin
                m_pend.push_back(make_entry(m_pc));
                if (m_faulty(m_pc)) m_fault = 1'b1;
                else                m_pc    = m_pc + 64'd4;
            end
        end
    end

    always @(negedge clk) begin : compare
        bit   iss;
        bit   req;
        ent_t h;
        if (m_live) begin
            iss = m_issue();
            req = iss && !m_faulty(m_pc);
            chk("mem_req",  64'(mem_req), 64'(req));
            chk("mem_addr", mem_addr, req ? m_pc : 64'd0);
            chk("if_valid", 64'(if_valid), 64'(m_q.size() > 0));
            if (m_q.size() > 0) h = m_q[0];
            else                h = '{64'd0, 32'h13, 1'b0, 4'd0, 64'd0};
            chk("if_pc",       if_pc, h.pc);
            chk("if_instr",    64'(if_instr), 64'(h.instr));
            chk("if_exc_en",   64'(if_exc_en), 64'(h.exc));
            chk("if_exc_code", 64'(if_exc_code), 64'(h.code));
            chk("if_exc_val",  if_exc_val, h.val);
        end
    end

    // Snapshot of the last driven cycle, plus collected pops for directed scenarios
    logic        s_req, s_valid, s_exc;
    logic [63:0] s_addr, s_pc, s_val;
    logic [31:0] s_instr;
    logic [3:0]  s_code;
    bit          collect = 1'b0;
    bit          bad_req = 1'b0;
    ent_t        got[$];

    task automatic cycle(input logic r, input logic re, input logic [63:0] rpc, input logic rdy);
        rst = r; redirect_en = re; redirect_pc = rpc; if_ready = rdy;
        #3;
        s_req = mem_req; s_addr = mem_addr; s_valid = if_valid; s_pc = if_pc;
        s_instr = if_instr; s_exc = if_exc_en; s_code = if_exc_code; s_val = if_exc_val;
        if (collect && if_valid && if_ready)
            got.push_back('{if_pc, if_instr, if_exc_en, if_exc_code, if_exc_val});
        if (collect && mem_req && mem_addr == 64'h2000) bad_req = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pick_target();
        logic [63:0] w;
        w = 64'($urandom_range(0, c_words - 1)) << 2;
        case ($urandom_range(0, 7))
            0, 1, 2: return w;
            3:       return 64'h1FF0 + (64'($urandom_range(0, 3)) << 2);
            4:       return w | 64'($urandom_range(1, 3));
            5:       return 64'h4000_0000_0000_0000;
            6:       return 64'hFFFF_FFFF_FFFF_FFFC;
            default: return 64'h0000_0001_0000_0000;
        endcase
    endfunction

    initial begin
        @(posedge clk);
        #1;
        repeat (2) cycle(1'b1, 1'b0, 64'd0, 1'b1);
        chk("rst_mem_req",  64'(s_req), 64'd0);
        chk("rst_mem_addr", s_addr, 64'd0);
        chk("rst_if_valid", 64'(s_valid), 64'd0);
        chk("rst_if_instr", 64'(s_instr), 64'h13);
        chk("rst_exc_val",  s_val, 64'd0);

        cycle(1'b0, 1'b0, 64'd0, 1'b1);
        chk("c0_mem_req",  64'(s_req), 64'd1);
        chk("c0_mem_addr", s_addr, 64'd0);
        chk("c0_if_valid", 64'(s_valid), 64'd0);
        cycle(1'b0, 1'b0, 64'd0, 1'b1);
        cycle(1'b0, 1'b0, 64'd0, 1'b1);
        chk("c2_if_valid", 64'(s_valid), 64'd1);
        chk("c2_if_pc",    s_pc, 64'd0);
        chk("c2_if_instr", 64'(s_instr), 64'd0);

        repeat (20) cycle(1'b0, 1'b0, 64'd0, 1'b1);
        chk("stream_pc",    s_pc, 64'd80);
        chk("stream_instr", 64'(s_instr), 64'd20);

        repeat (5) cycle(1'b0, 1'b0, 64'd0, 1'b0);
        chk("bp_mem_req",  64'(s_req), 64'd0);
        chk("bp_if_valid", 64'(s_valid), 64'd1);
        repeat (10) cycle(1'b0, 1'b0, 64'd0, 1'b1);

        cycle(1'b0, 1'b1, 64'h40, 1'b1);
        cycle(1'b0, 1'b0, 64'd0, 1'b1);
        chk("rd1_if_valid", 64'(s_valid), 64'd0);
        chk("rd1_mem_addr", s_addr, 64'h40);
        cycle(1'b0, 1'b0, 64'd0, 1'b1);
        chk("rd2_if_valid", 64'(s_valid), 64'd0);
        cycle(1'b0, 1'b0, 64'd0, 1'b1);
        chk("rd3_if_valid", 64'(s_valid), 64'd1);
        chk("rd3_if_pc",    s_pc, 64'h40);
        chk("rd3_if_instr", 64'(s_instr), 64'd16);

        cycle(1'b0, 1'b1, 64'h1FFC, 1'b1);
        got.delete(); bad_req = 1'b0; collect = 1'b1;
        repeat (8) cycle(1'b0, 1'b0, 64'd0, 1'b1);
        collect = 1'b0;
        chk("oob_count", 64'(got.size()), 64'd2);
        while (got.size() < 2) got.push_back('{64'd0, 32'd0, 1'b0, 4'd0, 64'd0});
        chk("oob_e0_pc",    got[0].pc, 64'h1FFC);
        chk("oob_e0_instr", 64'(got[0].instr), 64'd2047);
        chk("oob_e0_exc",   64'(got[0].exc), 64'd0);
        chk("oob_e1_pc",    got[1].pc, 64'h2000);
        chk("oob_e1_exc",   64'(got[1].exc), 64'd1);
        chk("oob_e1_code",  64'(got[1].code), 64'd1);
        chk("oob_e1_val",   got[1].val, 64'h2000);
        chk("oob_e1_instr", 64'(got[1].instr), 64'h13);
        chk("oob_no_req",   64'(bad_req), 64'd0);
        chk("oob_idle_req", 64'(s_req), 64'd0);

        cycle(1'b0, 1'b1, 64'h102, 1'b1);
        got.delete(); collect = 1'b1;
        repeat (6) cycle(1'b0, 1'b0, 64'd0, 1'b1);
        collect = 1'b0;
        chk("mis_count", 64'(got.size()), 64'd1);
        while (got.size() < 1) got.push_back('{64'd0, 32'd0, 1'b0, 4'd0, 64'd0});
        chk("mis_pc",    got[0].pc, 64'h102);
        chk("mis_exc",   64'(got[0].exc), 64'd1);
        chk("mis_code",  64'(got[0].code), 64'd0);
        chk("mis_val",   got[0].val, 64'h102);
        chk("mis_instr", 64'(got[0].instr), 64'h13);

        cycle(1'b0, 1'b1, 64'h100, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 64'd0, 1'b1);
        chk("resume_valid", 64'(s_valid), 64'd1);
        chk("resume_pc",    s_pc, 64'h100);
        chk("resume_instr", 64'(s_instr), 64'd64);

        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 299) == 0,
                  $urandom_range(0, 19) == 0,
                  pick_target(),
                  $urandom_range(0, 9) < 7);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
